epcs_flash_responder: RTL and testbench
=======================================

// Module: epcs_flash_responder
// PURPOSE
//  Serial-flash responder: the device end of the platform's flash_as_* (EPCS/ASMI) master interface.
//  Answers READ (0x03), RDSR (0x05) and RES/read-ID (0xAB) from an internal byte memory.
//  The memory is preloaded through a local write port.
//  Used as a flash stand-in for board bring-up and as the flash model in platform simulation.
//  All SPI inputs are oversampled on clk. No second clock domain is used.
// PARAMETERS
//  ADDR_W      12     memory address width; DEPTH = 2**ADDR_W bytes
//  SILICON_ID  8'h12  byte returned by RES (0xAB)
//  STATUS_VAL  8'h00  byte returned by RDSR; bit0 (WIP) is always 0
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       asynchronous active-low reset
//  flash_dclk    in   1       serial clock from master; half-period >= 4 clk
//  flash_sce     in   1       chip select from master, active low
//  flash_sdo     in   1       master-out data, sampled on dclk rising edge
//  flash_data0   out  1       responder-out data, changes after dclk falling edge
//  load_we       in   1       preload write strobe
//  load_addr     in   ADDR_W  preload address
//  load_data     in   8       preload byte
//  busy          out  1       high while a transaction is selected (sce low)
//  cmd_count     out  16      count of completed valid command bytes; wraps at 0xFFFF
// BEHAVIOUR
//  Reset: flash_data0=1, busy=0, cmd_count=0, FSM=IDLE, counters=0. Memory contents are not reset.
//  Input sync: dclk, sce and sdo each pass through a 2-FF synchronizer.
//   Edges are detected on the synchronized dclk.
//   sdo is sampled on a detected rise, from the same sync stage as dclk.
//  FSM states: IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
//  Synchronized sce high forces IDLE and flash_data0=1 at any point; this is the abort path.
//  IDLE -> CMD on synchronized sce falling; bit_cnt=0.
//  CMD: shift in 8 bits MSB-first on rises. On the 8th bit, cmd_count increments for valid commands, then:
//   0x03 -> ADDR; 0x05 -> DATA with shift byte=STATUS_VAL; 0xAB -> DUMMY; any other -> IGNORE.
//  ADDR: shift in 24 bits MSB-first.
//   Keep the low ADDR_W bits as the address; upper bits are ignored.
//   On the 24th bit, read mem[addr] (1-clk read) into the shift byte -> DATA.
//  DUMMY: 24 bits are shifted in and discarded; then shift byte=SILICON_ID -> DATA.
//  DATA: on each dclk fall, drive the shift byte MSB-first on flash_data0.
//   flash_data0 updates <= 3 clk after the fall.
//   When bit0 of a byte is driven:
//    READ: addr = addr+1 mod DEPTH, prefetch mem[addr] as the next byte.
//    RDSR: next byte is STATUS_VAL again.
//    RES: next byte is SILICON_ID again.
//  IGNORE: flash_data0=1; all edges are ignored until sce rises.
//  Falls in CMD/ADDR/DUMMY are ignored. Mode 0 and mode 3 masters are both supported.
//  Bytes stream without limit while sce stays low. Address wraps DEPTH-1 -> 0.
//  load_we: write mem[load_addr]=load_data in the same cycle; allowed at any time.
//   If it coincides with a fetch of the same address, the fetch returns the old byte (read-first).
//  busy = synchronized sce inverted.
//  cmd_count counts 0x03/0x05/0xAB only.
//  Async reset mid-transfer: the FSM goes to IDLE immediately.
//   While sce stays low after reset, no command is decoded until the next sce falling edge.
// TESTING
//  1. Preload mem[0x010..0x013]=A1,B2,C3,D4; READ addr 0x000010, clock 32 data bits
//     -> data0 = A1 B2 C3 D4 MSB-first; cmd_count=1.
//  2. Preload mem[DEPTH-1]=5A, mem[0]=C3; READ at DEPTH-1, 2 bytes -> 5A then C3 (wrap).
//  3. RDSR, 3 bytes -> 00 00 00. Then RES plus 3 dummy bytes, 2 bytes -> 12 12; cmd_count=2.
//  4. Unknown command 0x06, then 16 clocks -> data0 held 1; cmd_count unchanged.
//     The next READ after sce high works normally.
//  5. Abort: sce rises after 12 address bits, new READ addr 0x000010
//     -> returns A1; no leftover bits from the aborted transfer.
//  6. Mode 3 (dclk idles high) with dclk half-period = 4 clk repeats test 1 with identical data.
//     rst_n pulsed low mid-DATA -> data0=1, busy follows sce.

Source files
------------

// File: rtl/epcs_flash_responder.sv
// Serial-flash responder: device end of an EPCS/ASMI master.
// Answers READ (0x03), RDSR (0x05) and RES (0xAB) from a preloadable byte memory.
// All SPI inputs are oversampled on clk through 2-FF synchronizers.
module epcs_flash_responder #(
    parameter int unsigned ADDR_W     = 12,
    parameter logic [7:0]  SILICON_ID = 8'h12,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flash_dclk,
    input  logic              flash_sce,
    input  logic              flash_sdo,
    output logic              flash_data0,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              busy,
    output logic [15:0]       cmd_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StData,
        StIgnore
    } state_e;

    typedef enum logic [1:0] {
        KindRead,
        KindRdsr,
        KindRes
    } kind_e;

    state_e              state_q;
    kind_e               kind_q;
    logic [1:0]          dclk_sync_q, sce_sync_q, sdo_sync_q;
    logic                dclk_q;
    logic                sce_q;
    logic [1:0]          settle_q;
    logic [4:0]          bit_cnt_q;
    logic [6:0]          shift_in_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          shift_out_q;
    logic                data0_q;
    logic [15:0]         cmd_count_q;
    logic                fetch_req_q;
    logic [ADDR_W-1:0]   fetch_addr_q;
    logic                load_pending_q;
    logic [7:0]          rd_data_q;
    logic [7:0]          mem [DEPTH];

    logic              dclk_s, sce_s, sdo_s;
    logic              rise, fall, sce_fall;
    logic [7:0]        cmd_byte;
    logic [ADDR_W-1:0] addr_shift;

    assign dclk_s     = dclk_sync_q[1];
    assign sce_s      = sce_sync_q[1];
    assign sdo_s      = sdo_sync_q[1];
    assign rise       = dclk_s & ~dclk_q;
    assign fall       = ~dclk_s & dclk_q;
    assign sce_fall   = sce_q & ~sce_s;
    assign cmd_byte   = {shift_in_q, sdo_s};
    assign addr_shift = {addr_q[ADDR_W-2:0], sdo_s};

    assign flash_data0 = data0_q;
    assign busy        = ~sce_s;
    assign cmd_count   = cmd_count_q;

    // Input synchronizers and edge history. sce history stays low until the sync chain
    // holds real input values, so a select already low at reset release is not a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dclk_sync_q <= 2'b00;
            sce_sync_q  <= 2'b11;
            sdo_sync_q  <= 2'b00;
            dclk_q      <= 1'b0;
            sce_q       <= 1'b0;
            settle_q    <= 2'd0;
        end else begin
            dclk_sync_q <= {dclk_sync_q[0], flash_dclk};
            sce_sync_q  <= {sce_sync_q[0], flash_sce};
            sdo_sync_q  <= {sdo_sync_q[0], flash_sdo};
            dclk_q      <= dclk_s;
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            sce_q <= (settle_q == 2'd2) ? sce_s : 1'b0;
        end
    end

    // Byte memory: preload write plus one-cycle fetch; a colliding fetch sees the old byte.
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem[load_addr] <= load_data;
        end
        if (fetch_req_q) begin
            rd_data_q <= mem[fetch_addr_q];
        end
    end

    // Transaction FSM with registered data output and command counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            kind_q         <= KindRead;
            bit_cnt_q      <= 5'd0;
            shift_in_q     <= 7'd0;
            addr_q         <= '0;
            shift_out_q    <= 8'd0;
            data0_q        <= 1'b1;
            cmd_count_q    <= 16'd0;
            fetch_req_q    <= 1'b0;
            fetch_addr_q   <= '0;
            load_pending_q <= 1'b0;
        end else begin
            fetch_req_q    <= 1'b0;
            load_pending_q <= fetch_req_q;
            if (load_pending_q) begin
                shift_out_q <= rd_data_q;
            end
            if (sce_s) begin
                // Deselect aborts whatever was in progress.
                state_q <= StIdle;
                data0_q <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        data0_q <= 1'b1;
                        if (sce_fall) begin
                            state_q   <= StCmd;
                            bit_cnt_q <= 5'd0;
                        end
                    end
                    StCmd: begin
                        if (rise) begin
                            shift_in_q <= cmd_byte[6:0];
                            bit_cnt_q  <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd7) begin
                                bit_cnt_q <= 5'd0;
                                case (cmd_byte)
                                    8'h03: begin
                                        kind_q      <= KindRead;
                                        state_q     <= StAddr;
                                        cmd_count_q <= cmd_count_q + 16'd1;
                                    end
                                    8'h05: begin
                                        kind_q      <= KindRdsr;
                                        shift_out_q <= STATUS_VAL;
                                        state_q     <= StData;
                                        cmd_count_q <= cmd_count_q + 16'd1;
                                    end
                                    8'hAB: begin
                                        kind_q      <= KindRes;
                                        state_q     <= StDummy;
                                        cmd_count_q <= cmd_count_q + 16'd1;
                                    end
                                    default: state_q <= StIgnore;
                                endcase
                            end
                        end
                    end
                    StAddr: begin
                        if (rise) begin
                            addr_q    <= addr_shift;
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q    <= 5'd0;
                                fetch_req_q  <= 1'b1;
                                fetch_addr_q <= addr_shift;
                                state_q      <= StData;
                            end
                        end
                    end
                    StDummy: begin
                        if (rise) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q == 5'd23) begin
                                bit_cnt_q   <= 5'd0;
                                shift_out_q <= SILICON_ID;
                                state_q     <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (fall) begin
                            data0_q     <= shift_out_q[7];
                            shift_out_q <= {shift_out_q[6:0], 1'b0};
                            bit_cnt_q   <= bit_cnt_q + 5'd1;
                            if (bit_cnt_q[2:0] == 3'd7) begin
                                // Last bit of the byte is out; queue up the next one.
                                bit_cnt_q <= 5'd0;
                                case (kind_q)
                                    KindRead: begin
                                        addr_q       <= addr_q + 1'b1;
                                        fetch_addr_q <= addr_q + 1'b1;
                                        fetch_req_q  <= 1'b1;
                                    end
                                    KindRdsr: shift_out_q <= STATUS_VAL;
                                    default:  shift_out_q <= SILICON_ID;
                                endcase
                            end
                        end
                    end
                    StIgnore: data0_q <= 1'b1;
                    default:  state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_epcs_flash_responder.sv
// Directed bench for epcs_flash_responder: expected bytes go into a scoreboard queue as
// stimulus is issued and are popped as bytes are clocked out of the responder.
module tb_epcs_flash_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flash_dclk;
    logic        flash_sce;
    logic        flash_sdo;
    logic        load_we;
    logic [11:0] load_addr;
    logic [7:0]  load_data;
    logic        flash_data0;
    logic        busy;
    logic [15:0] cmd_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   half  = 5;
    bit   mode3 = 1'b0;
    int   exp_count = 0;
    logic [7:0] exp_q[$];

    epcs_flash_responder #(
        .ADDR_W     (12),
        .SILICON_ID (8'h12),
        .STATUS_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flash_dclk  (flash_dclk),
        .flash_sce   (flash_sce),
        .flash_sdo   (flash_sdo),
        .flash_data0 (flash_data0),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .busy        (busy),
        .cmd_count   (cmd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift nbits of tx MSB-first; rx collects data0 sampled just before each rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (mode3) flash_dclk = 1'b0;
            flash_sdo = tx[7-i];
            repeat (half) @(negedge clk);
            rx = {rx[6:0], flash_data0};
            flash_dclk = 1'b1;
            repeat (half) @(negedge clk);
            if (!mode3) flash_dclk = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] dummy;
        xfer(b, 8, dummy);
    endtask

    task automatic recv_check(input string tag);
        logic [7:0] r;
        logic [7:0] e;
        xfer(8'h00, 8, r);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, r);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'd0, r}, {24'd0, e});
        end
    endtask

    task automatic sel();
        flash_sce = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic desel();
        flash_dclk = mode3;
        @(negedge clk);
        flash_sce = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] d);
        load_we   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_we   = 1'b0;
    endtask

    task automatic read(input logic [23:0] a, input int nbytes, input string tag);
        sel();
        send(8'h03);
        send(a[23:16]);
        send(a[15:8]);
        send(a[7:0]);
        for (int i = 0; i < nbytes; i++) recv_check(tag);
        desel();
        exp_count++;
    endtask

    initial begin
        logic [7:0] junk;
        rst_n = 1'b0;
        flash_dclk = 1'b0;
        flash_sce = 1'b1;
        flash_sdo = 1'b0;
        load_we = 1'b0;
        load_addr = 12'h000;
        load_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_data0", {31'd0, flash_data0}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_cmd_count", {16'd0, cmd_count}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Plain READ of four bytes.
        load(12'h010, 8'hA1);
        load(12'h011, 8'hB2);
        load(12'h012, 8'hC3);
        load(12'h013, 8'hD4);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hD4);
        read(24'h000010, 4, "read_basic");
        check("count_t1", {16'd0, cmd_count}, exp_count);

        // Wrap from DEPTH-1 to 0; upper address bits are don't-care.
        load(12'hFFF, 8'h5A);
        load(12'h000, 8'hC3);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        read(24'h123FFF, 2, "read_wrap");
        check("count_t2", {16'd0, cmd_count}, exp_count);

        // RDSR repeats status; RES repeats silicon id after 3 dummy bytes.
        sel();
        send(8'h05);
        repeat (3) exp_q.push_back(8'h00);
        repeat (3) recv_check("rdsr");
        desel();
        exp_count++;
        sel();
        send(8'hAB);
        repeat (3) send(8'h00);
        repeat (2) exp_q.push_back(8'h12);
        repeat (2) recv_check("res_id");
        desel();
        exp_count++;
        check("count_t3", {16'd0, cmd_count}, exp_count);

        // Unknown command: output held high, not counted.
        sel();
        send(8'h06);
        repeat (2) exp_q.push_back(8'hFF);
        repeat (2) recv_check("ignore");
        desel();
        check("count_t4", {16'd0, cmd_count}, exp_count);
        exp_q.push_back(8'hA1);
        read(24'h000010, 1, "read_after_ignore");

        // Abort after 12 address bits, then a clean READ.
        sel();
        send(8'h03);
        xfer(8'h00, 8, junk);
        xfer(8'hF0, 4, junk);
        desel();
        exp_count++;
        check("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        read(24'h000010, 2, "read_after_abort");
        check("count_t5", {16'd0, cmd_count}, exp_count);

        // Mode 3 at minimum half-period.
        mode3 = 1'b1;
        half = 4;
        flash_dclk = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hD4);
        read(24'h000010, 4, "read_mode3");
        check("count_t6", {16'd0, cmd_count}, exp_count);

        // Reset pulse in the middle of a data byte.
        sel();
        send(8'h03);
        send(8'h00);
        send(8'h00);
        send(8'h11);
        exp_q.push_back(8'hB2);
        recv_check("read_pre_reset");
        xfer(8'h00, 3, junk);
        rst_n = 1'b0;
        #1;
        check("rst_data0", {31'd0, flash_data0}, 32'd1);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_count", {16'd0, cmd_count}, 32'd0);
        exp_count = 0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd1);
        check("post_rst_data0", {31'd0, flash_data0}, 32'd1);
        send(8'h03);
        send(8'h00);
        send(8'h00);
        send(8'h10);
        exp_q.push_back(8'hFF);
        recv_check("post_rst_no_decode");
        check("post_rst_count", {16'd0, cmd_count}, 32'd0);
        desel();
        check("post_rst_busy_low", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'hA1);
        read(24'h000010, 1, "read_post_reset");
        check("count_final", {16'd0, cmd_count}, exp_count);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
